// File: rtl/fp_mult_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package fp_mult_arbiter_pkg;

  localparam int FP_W      = 32;
  localparam int STATUS_W  = 8;
  // Widest requester index for the supported range of up to 8 requesters.
  localparam int TAG_W_MAX = 3;

  // Bit positions inside the multiplier status byte.
  localparam int STATUS_INEXACT   = 0;
  localparam int STATUS_UNDERFLOW = 1;
  localparam int STATUS_OVERFLOW  = 2;
  localparam int STATUS_INFINITE  = 3;
  localparam int STATUS_INVALID   = 4;
  localparam int STATUS_ZERO      = 5;

  typedef enum logic [2:0] {
    RND_NEAREST_EVEN = 3'd0,
    RND_TO_ZERO      = 3'd1,
    RND_TO_POS_INF   = 3'd2,
    RND_TO_NEG_INF   = 3'd3,
    RND_NEAREST_MAX  = 3'd4
  } round_values_e;

  // Tag carried alongside each operation in flight through the core.
  typedef struct packed {
    logic                 v;
    logic [TAG_W_MAX-1:0] tag;
  } fp_tag_t;

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// Requester-side bundle: operand request ports and the shared response bus.
interface fp_mult_arbiter_if #(
  parameter int NREQ = 4
) ();
  import fp_mult_arbiter_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [FP_W-1:0]      rsp_z;
  logic [STATUS_W-1:0]  rsp_status;

  // Requesting engines.
  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_z, rsp_status
  );

  // Arbiter.
  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_z, rsp_status
  );
endinterface

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  int best_d;
  int d;

  // Pick the valid requester with the smallest circular distance from ptr.
  always_comb begin
    best_d  = N;
    d       = 0;
    gnt_idx = '0;
    gnt     = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr)) % N;
      if (en && req[i] && (d < best_d)) begin
        best_d  = d;
        gnt_idx = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = (best_d < N) && (gnt_idx == W'(i));
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters; tags route results back.
module fp_mult_arbiter
  import fp_mult_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 2,
  parameter int TAG_W    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  fp_mult_arbiter_if.slave    bus,
  input  logic                issue_hold,
  output logic [FP_W-1:0]     mult_a,
  output logic [FP_W-1:0]     mult_b,
  input  logic [FP_W-1:0]     mult_z,
  input  logic [STATUS_W-1:0] mult_status,
  output logic                busy
);

  logic [TAG_W-1:0]    ptr;
  logic [TAG_W-1:0]    gnt_idx;
  logic [NREQ-1:0]     gnt;
  logic                hs;
  logic [FP_W-1:0]     sel_a;
  logic [FP_W-1:0]     sel_b;
  fp_tag_t             issue_tag;
  fp_tag_t             tag_pipe [MULT_LAT];
  logic [MULT_LAT-1:0] tag_v;

  rr_arbiter #(.N(NREQ), .W(TAG_W)) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .en      (!issue_hold && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign hs            = |gnt;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = bus.req_a[i*FP_W +: FP_W];
        sel_b = bus.req_b[i*FP_W +: FP_W];
      end
    end
  end

  // Round-robin pointer moves just past the winner; frozen without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (gnt_idx == TAG_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Issue register: operands held for the core, tag rides alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_a    <= '0;
      mult_b    <= '0;
      issue_tag <= '0;
    end else begin
      issue_tag.v   <= hs;
      issue_tag.tag <= TAG_W_MAX'(gnt_idx);
      if (hs) begin
        mult_a <= sel_a;
        mult_b <= sel_b;
      end
    end
  end

  // Tag pipe: the core samples the issue register one edge later, so these
  // MULT_LAT stages line the tag up with mult_z at the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MULT_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < MULT_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Response register: capture the product and pulse the owner's valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid  <= '0;
      bus.rsp_z      <= '0;
      bus.rsp_status <= '0;
    end else if (tag_pipe[MULT_LAT-1].v) begin
      bus.rsp_valid  <= NREQ'(1) << tag_pipe[MULT_LAT-1].tag;
      bus.rsp_z      <= mult_z;
      bus.rsp_status <= mult_status;
    end else begin
      bus.rsp_valid <= '0;
    end
  end

  // Occupancy of every stage for the busy flag.
  always_comb begin
    for (int i = 0; i < MULT_LAT; i++) tag_v[i] = tag_pipe[i].v;
  end

  assign busy = issue_tag.v | (|tag_v) | (|bus.rsp_valid);

endmodule
